mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction fetch and the load/store unit.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_timer.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Imported by the arbiter top and its timeout counter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_LS = 1'b1;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      if (max_val < 2) begin
         return 1;
      end else begin
         return $clog2(max_val + 1);
      end
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Bus-timeout counter: counts BUSY cycles since the last grant.
// expired flags the final allowed cycle; it is constant 0 when TIMEOUT is 0.
module mem_arb_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int             TW       = cnt_width(TIMEOUT);
   localparam bit             TIMER_ON = (TIMEOUT != 0);
   localparam logic [TW-1:0]  LAST_CNT = (TIMEOUT == 0) ? {TW{1'b0}} : TW'(TIMEOUT - 1);

   logic [TW-1:0] tcnt_q;
   logic [TW-1:0] tcnt_d;

   // Next count: clear wins over enable; the counter is frozen when timeouts are off.
   always_comb begin
      tcnt_d = tcnt_q;
      if (clear) begin
         tcnt_d = {TW{1'b0}};
      end else if (enable && TIMER_ON) begin
         tcnt_d = tcnt_q + TW'(1);
      end else begin
         tcnt_d = tcnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_q <= {TW{1'b0}};
      end else begin
         tcnt_q <= tcnt_d;
      end
   end

   assign expired = TIMER_ON && (tcnt_q == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// Load/store has priority, bounded by a streak limit so fetch cannot starve.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MAX_LS_STREAK = 4,
   parameter int TIMEOUT       = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_ack,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_err,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wstrb,
   output logic                ls_ack,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                ls_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                owner
);

   localparam int            SW         = cnt_width(MAX_LS_STREAK);
   localparam int            STRB_W     = DATA_W / 8;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

   arb_state_e          state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
   logic                owner_q, owner_d;
   logic [SW-1:0]       streak_q, streak_d;
   logic                if_ack_q, if_ack_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic                if_err_q, if_err_d;
   logic                ls_ack_q, ls_ack_d;
   logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
   logic                ls_err_q, ls_err_d;

   logic                grant_s;
   logic                ls_win_s;
   logic                expired_s;
   logic                resp_s;
   logic                resp_err_s;
   logic [DATA_W-1:0]   resp_data_s;

   assign ls_win_s = ls_req && !(if_req && (streak_q == STREAK_MAX));

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (grant_s),
      .enable  (state_q == ARB_BUSY),
      .expired (expired_s)
   );

   // Next-state, grant and response logic.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      owner_d     = owner_q;
      streak_d    = streak_q;
      if_ack_d    = 1'b0;
      if_rdata_d  = {DATA_W{1'b0}};
      if_err_d    = 1'b0;
      ls_ack_d    = 1'b0;
      ls_rdata_d  = {DATA_W{1'b0}};
      ls_err_d    = 1'b0;
      grant_s     = 1'b0;
      resp_s      = 1'b0;
      resp_err_s  = 1'b0;
      resp_data_s = {DATA_W{1'b0}};

      case (state_q)
         ARB_IDLE: begin
            if (ls_req || if_req) begin
               grant_s   = 1'b1;
               mem_req_d = 1'b1;
               state_d   = ARB_BUSY;
               if (ls_win_s) begin
                  owner_d     = OWNER_LS;
                  mem_we_d    = ls_we;
                  mem_addr_d  = ls_addr;
                  mem_wdata_d = ls_wdata;
                  mem_wstrb_d = ls_wstrb;
                  // Streak only grows while fetch is actually being held off.
                  if (!if_req) begin
                     streak_d = {SW{1'b0}};
                  end else if (streak_q == STREAK_MAX) begin
                     streak_d = streak_q;
                  end else begin
                     streak_d = streak_q + SW'(1);
                  end
               end else begin
                  owner_d     = OWNER_IF;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = {DATA_W{1'b0}};
                  mem_wstrb_d = {STRB_W{1'b0}};
                  streak_d    = {SW{1'b0}};
               end
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            if (mem_ack) begin
               mem_req_d   = 1'b0;
               state_d     = ARB_RESP;
               resp_s      = 1'b1;
               resp_data_s = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
            end else if (expired_s) begin
               mem_req_d  = 1'b0;
               state_d    = ARB_RESP;
               resp_s     = 1'b1;
               resp_err_s = 1'b1;
            end else begin
               state_d = ARB_BUSY;
            end
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d   = ARB_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      // The completion is routed only to the owner; the other port stays quiet.
      if (resp_s) begin
         if (owner_q == OWNER_LS) begin
            ls_ack_d   = 1'b1;
            ls_rdata_d = resp_data_s;
            ls_err_d   = resp_err_s;
         end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = resp_data_s;
            if_err_d   = resp_err_s;
         end
      end else begin
         if_ack_d = 1'b0;
         ls_ack_d = 1'b0;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         mem_wstrb_q <= {STRB_W{1'b0}};
         owner_q     <= OWNER_IF;
         streak_q    <= {SW{1'b0}};
         if_ack_q    <= 1'b0;
         if_rdata_q  <= {DATA_W{1'b0}};
         if_err_q    <= 1'b0;
         ls_ack_q    <= 1'b0;
         ls_rdata_q  <= {DATA_W{1'b0}};
         ls_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         owner_q     <= owner_d;
         streak_q    <= streak_d;
         if_ack_q    <= if_ack_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         ls_ack_q    <= ls_ack_d;
         ls_rdata_q  <= ls_rdata_d;
         ls_err_q    <= ls_err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign owner     = owner_q;
   assign if_ack    = if_ack_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign ls_ack    = ls_ack_q;
   assign ls_rdata  = ls_rdata_q;
   assign ls_err    = ls_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with an 8-cycle timeout,
// a second with timeouts disabled.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [31:0] ls_addr = 32'h0;
   logic [31:0] ls_wdata = 32'h0;
   logic [3:0]  ls_wstrb = 4'h0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   logic        if_ack, if_err, ls_ack, ls_err, mem_req, mem_we, owner;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   logic        if_req1 = 1'b0;
   logic        ls_req1 = 1'b0;
   logic        mem_ack1 = 1'b0;
   logic        if_ack1, if_err1, ls_ack1, ls_err1, mem_req1, mem_we1, owner1;
   logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1;
   logic [3:0]  mem_wstrb1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LS_STREAK(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
      .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(owner)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LS_STREAK(4), .TIMEOUT(0)) dut_nto (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1), .if_err(if_err1),
      .ls_req(ls_req1), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
      .ls_ack(ls_ack1), .ls_rdata(ls_rdata1), .ls_err(ls_err1),
      .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_wstrb(mem_wstrb1), .mem_ack(mem_ack1), .mem_rdata(mem_rdata), .owner(owner1)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for mem_req on the selected instance (0 = dut, 1 = dut_nto).
   task automatic wait_mem_req(input bit which);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         seen = which ? mem_req1 : mem_req;
         if (seen) break;
         tick();
      end
      check_val("wait_mem_req", {63'd0, seen}, 64'd1);
   endtask

   logic exp_owner [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      // Reset
      tick(); tick();
      rst = 1'b0;
      tick();
      check_val("rst_mem_req", {63'd0, mem_req}, 64'd0);
      check_val("rst_acks", {62'd0, if_ack, ls_ack}, 64'd0);
      check_val("rst_owner", {63'd0, owner}, 64'd0);
      check_val("rst_mem_addr", {32'd0, mem_addr}, 64'd0);

      // 1: single fetch, one-cycle memory latency
      if_addr = 32'h10;
      if_req  = 1'b1;
      tick();
      check_val("t1_mem_req", {63'd0, mem_req}, 64'd1);
      check_val("t1_mem_addr", {32'd0, mem_addr}, 64'h10);
      check_val("t1_we_strb", {59'd0, mem_we, mem_wstrb}, 64'd0);
      check_val("t1_owner", {63'd0, owner}, 64'd0);
      check_val("t1_no_early_ack", {63'd0, if_ack}, 64'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ack = 1'b0;
      check_val("t1_if_ack", {63'd0, if_ack}, 64'd1);
      check_val("t1_if_rdata", {32'd0, if_rdata}, 64'hDEADBEEF);
      check_val("t1_if_err", {63'd0, if_err}, 64'd0);
      check_val("t1_ls_ack", {63'd0, ls_ack}, 64'd0);
      check_val("t1_mem_req_drop", {63'd0, mem_req}, 64'd0);
      if_req = 1'b0;
      tick();
      check_val("t1_ack_pulse", {63'd0, if_ack}, 64'd0);
      check_val("t1_rdata_clr", {32'd0, if_rdata}, 64'd0);

      // 2: both requesting continuously -> LS x4, IF, LS
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_addr = 32'h400;
      if_req  = 1'b1;
      if_addr = 32'h500;
      for (int i = 0; i < 6; i++) begin
         wait_mem_req(1'b0);
         check_val($sformatf("t2_owner%0d", i), {63'd0, owner}, {63'd0, exp_owner[i]});
         check_val($sformatf("t2_addr%0d", i), {32'd0, mem_addr},
                   exp_owner[i] ? 64'h400 : 64'h500);
         mem_ack   = 1'b1;
         mem_rdata = 32'hA0 + 32'(i);
         tick();
         mem_ack = 1'b0;
         check_val($sformatf("t2_acks%0d", i), {62'd0, if_ack, ls_ack},
                   exp_owner[i] ? 64'd1 : 64'd2);
         check_val($sformatf("t2_rdata%0d", i), {32'd0, exp_owner[i] ? ls_rdata : if_rdata},
                   64'hA0 + 64'(i));
         if (i == 5) begin
            ls_req = 1'b0;
            if_req = 1'b0;
         end
         tick();
      end

      // 3: byte-masked store
      ls_req   = 1'b1;
      ls_we    = 1'b1;
      ls_addr  = 32'h100;
      ls_wdata = 32'h12345678;
      ls_wstrb = 4'b0011;
      wait_mem_req(1'b0);
      check_val("t3_owner", {63'd0, owner}, 64'd1);
      check_val("t3_we_strb", {59'd0, mem_we, mem_wstrb}, 64'h13);
      check_val("t3_addr", {32'd0, mem_addr}, 64'h100);
      check_val("t3_wdata", {32'd0, mem_wdata}, 64'h12345678);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      tick();
      mem_ack = 1'b0;
      check_val("t3_acks", {62'd0, if_ack, ls_ack}, 64'd1);
      check_val("t3_rdata", {32'd0, ls_rdata}, 64'd0);
      check_val("t3_err", {63'd0, ls_err}, 64'd0);
      ls_req = 1'b0;
      tick();

      // 4: load with memory silent -> timeout after 8 BUSY cycles
      ls_req    = 1'b1;
      ls_we     = 1'b0;
      ls_addr   = 32'h200;
      mem_rdata = 32'h55555555;
      wait_mem_req(1'b0);
      for (int k = 0; k < 7; k++) tick();
      check_val("t4_still_busy", {62'd0, mem_req, ls_ack}, 64'd2);
      tick();
      check_val("t4_req_drop", {63'd0, mem_req}, 64'd0);
      check_val("t4_acks", {62'd0, if_ack, ls_ack}, 64'd1);
      check_val("t4_err", {63'd0, ls_err}, 64'd1);
      check_val("t4_rdata", {32'd0, ls_rdata}, 64'd0);
      ls_req = 1'b0;
      tick();
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check_val("t4_late_ack", {61'd0, mem_req, if_ack, ls_ack}, 64'd0);
      tick();
      check_val("t4_late_ack2", {61'd0, mem_req, if_ack, ls_ack}, 64'd0);

      // 5: reset while BUSY with a store, then a stray mem_ack
      ls_req   = 1'b1;
      ls_we    = 1'b1;
      ls_addr  = 32'h300;
      ls_wstrb = 4'hF;
      wait_mem_req(1'b0);
      rst    = 1'b1;
      ls_req = 1'b0;
      tick();
      check_val("t5_outs", {56'd0, mem_req, mem_we, owner, mem_wstrb, if_ack}, 64'd0);
      check_val("t5_addr", {32'd0, mem_addr}, 64'd0);
      rst     = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check_val("t5_no_ack", {61'd0, mem_req, if_ack, ls_ack}, 64'd0);

      // 6: timeouts disabled, memory slow for 12 cycles
      if_addr = 32'h80;
      if_req1 = 1'b1;
      wait_mem_req(1'b1);
      for (int k = 0; k < 12; k++) tick();
      check_val("t6_busy", {61'd0, mem_req1, if_ack1, if_err1}, 64'd4);
      check_val("t6_addr", {32'd0, mem_addr1}, 64'h80);
      mem_ack1  = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack1 = 1'b0;
      if_req1  = 1'b0;
      check_val("t6_ack", {61'd0, if_ack1, if_err1, ls_ack1}, 64'd4);
      check_val("t6_rdata", {32'd0, if_rdata1}, 64'hCAFEF00D);
      tick();
      check_val("t6_pulse", {62'd0, if_ack1, mem_req1}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
